// File: rtl/csd_encoder_seq.sv
// Sequential binary to canonical-signed-digit encoder.
// Resolves DPC digits per clock; valid/ready on both sides.
module csd_encoder_seq #(
   parameter int WIDTH = 16,
   parameter int DPC   = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                in_data,
   input  logic                            in_signed,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH:0]                  out_pos,
   output logic [WIDTH:0]                  out_neg,
   output logic [$clog2(WIDTH+2)-1:0]      nz_count
);

   localparam int CNT_W = $clog2(WIDTH+2);
   localparam int NSTEP = (WIDTH + DPC) / DPC;
   localparam int IW    = $clog2(NSTEP*DPC + 1);
   localparam int SW    = $clog2(NSTEP + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] opnd;
   logic             sgn;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [SW-1:0]    step;
   logic             last;
   logic             accept;
   logic             ready_n, valid_n;

   logic             c;
   logic             xi, xn;
   int               p;
   logic [WIDTH:0]   pos_n, neg_n;
   logic [CNT_W-1:0] add;

   // Extended operand bit: beyond the MSB it is the sign bit or zero.
   function automatic logic ext(input logic [WIDTH-1:0] v,
                                input logic sg, input int i);
      if (i < WIDTH) return v[i];
      return sg & v[WIDTH-1];
   endfunction

   assign last   = (step == SW'(NSTEP-1));
   assign accept = in_valid & in_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (accept)    state_n = CONV;
         CONV:    if (last)      state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   // Handshake outputs are registered copies of the next state.
   always_comb begin
      ready_n = (state_n == IDLE);
      valid_n = (state_n == DONE);
   end

   // Handshake output registers; ready stays low through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= ready_n;
         out_valid <= valid_n;
      end
   end

   // One step of DPC digits with the carry chained inside the clock.
   always_comb begin
      c     = carry;
      pos_n = out_pos;
      neg_n = out_neg;
      add   = '0;
      p     = 0;
      xi    = 1'b0;
      xn    = 1'b0;
      for (int k = 0; k < DPC; k++) begin
         p = int'(idx) + k;
         if (p <= WIDTH) begin
            xi = ext(opnd, sgn, p);
            xn = ext(opnd, sgn, p + 1);
            if (xi ^ c) begin
               if (xn) begin
                  neg_n[p] = 1'b1;
                  c        = 1'b1;
               end else begin
                  pos_n[p] = 1'b1;
                  c        = 1'b0;
               end
               add = add + CNT_W'(1);
            end else begin
               c = xi & c;
            end
         end
      end
   end

   // Operand capture and result accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opnd     <= '0;
         sgn      <= 1'b0;
         carry    <= 1'b0;
         idx      <= '0;
         step     <= '0;
         out_pos  <= '0;
         out_neg  <= '0;
         nz_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  opnd     <= in_data;
                  sgn      <= in_signed;
                  carry    <= 1'b0;
                  idx      <= '0;
                  step     <= '0;
                  out_pos  <= '0;
                  out_neg  <= '0;
                  nz_count <= '0;
               end
            end
            CONV: begin
               carry    <= c;
               idx      <= idx + IW'(DPC);
               step     <= step + SW'(1);
               out_pos  <= pos_n;
               out_neg  <= neg_n;
               nz_count <= nz_count + add;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csd_encoder_seq.sv
// Scoreboard bench for csd_encoder_seq.
// Three configurations run side by side on one clock.
module tb_csd_encoder_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input int cf, input string nm,
                      input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL cfg%0d %s: actual %0h required %0h",
                  cf, nm, act, req);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int W  = (g == 0) ? 16 : ((g == 1) ? 8 : 17);
      localparam int D  = (g == 0) ? 1  : ((g == 1) ? 3 : 4);
      localparam int CW = $clog2(W+2);
      localparam int NS = (W + D) / D;

      logic          rst_n, in_valid, in_ready, in_signed;
      logic          out_valid, out_ready;
      logic [W-1:0]  in_data;
      logic [W:0]    out_pos, out_neg;
      logic [CW-1:0] nz_count;
      bit            fin   = 1'b0;
      bit            rmode = 1'b0;

      logic [W:0]    qp[$];
      logic [W:0]    qn[$];
      int            qc[$];
      time           qt[$];

      csd_encoder_seq #(.WIDTH(W), .DPC(D)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_data   (in_data),
         .in_signed (in_signed),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_pos   (out_pos),
         .out_neg   (out_neg),
         .nz_count  (nz_count)
      );

      // Non-adjacent form of the operand value, by repeated division.
      function automatic void naf(input logic [W-1:0] d, input bit s,
                                  output logic [W:0] p,
                                  output logic [W:0] n,
                                  output int c);
         longint v;
         v = s ? longint'($signed(d)) : longint'(d);
         p = '0;
         n = '0;
         c = 0;
         for (int i = 0; i <= W; i++) begin
            if (v[0]) begin
               if (v[1]) begin
                  n[i] = 1'b1;
                  v    = v + 1;
               end else begin
                  p[i] = 1'b1;
                  v    = v - 1;
               end
               c++;
            end
            v = v >>> 1;
         end
      endfunction

      task automatic tick();
         @(posedge clk);
         #1;
         if (rmode) out_ready = ($urandom % 4) != 0;
      endtask

      task automatic send(input logic [63:0] d, input bit s,
                          input logic [63:0] ep, input logic [63:0] en,
                          input int ec, input bit push);
         int n;
         n         = 0;
         in_valid  = 1'b1;
         in_data   = d[W-1:0];
         in_signed = s;
         while (!in_ready && n < 300) begin
            tick();
            n++;
         end
         chk(g, "accept", 64'(in_ready), 64'd1);
         if (in_ready && push) begin
            qp.push_back(ep[W:0]);
            qn.push_back(en[W:0]);
            qc.push_back(ec);
            qt.push_back($time + 9);
         end
         tick();
         in_valid = 1'b0;
         in_data  = W'($urandom);
      endtask

      task automatic send_m(input logic [W-1:0] d, input bit s);
         logic [W:0] p, n;
         int c;
         naf(d, s, p, n, c);
         send(64'(d), s, 64'(p), 64'(n), c, 1'b1);
      endtask

      task automatic drain();
         int n;
         n = 0;
         while (qp.size() != 0 && n < 3000) begin
            tick();
            n++;
         end
         chk(g, "drain", 64'(qp.size()), 64'd0);
      endtask

      // Monitor: compare every presented result against the queue head.
      initial begin
         bit was;
         was = 1'b0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               was = 1'b0;
            end else if (out_valid) begin
               if (qp.size() == 0) begin
                  chk(g, "unexpected_valid", 64'(out_valid), 64'd0);
               end else begin
                  if (!was)
                     chk(g, "latency", 64'(($time - qt[0] - 5) / 10),
                         64'(NS));
                  chk(g, "pos", 64'(out_pos), 64'(qp[0]));
                  chk(g, "neg", 64'(out_neg), 64'(qn[0]));
                  chk(g, "nz_count", 64'(nz_count), 64'(qc[0]));
                  chk(g, "disjoint", 64'(out_pos & out_neg), 64'd0);
                  if (out_ready) begin
                     void'(qp.pop_front());
                     void'(qn.pop_front());
                     void'(qc.pop_front());
                     void'(qt.pop_front());
                  end
               end
               was = !out_ready;
            end else begin
               was = 1'b0;
            end
         end
      end

      // Driver: reset, directed cases, backpressure, reset, random.
      initial begin
         logic [63:0] ones, msb, alt;
         logic [W-1:0] d;
         int sel;
         rst_n     = 1'b0;
         in_valid  = 1'b0;
         in_data   = '0;
         in_signed = 1'b0;
         out_ready = 1'b1;
         repeat (3) tick();
         chk(g, "rst_in_ready", 64'(in_ready), 64'd0);
         chk(g, "rst_out_valid", 64'(out_valid), 64'd0);
         chk(g, "rst_pos", 64'(out_pos), 64'd0);
         chk(g, "rst_neg", 64'(out_neg), 64'd0);
         chk(g, "rst_nz", 64'(nz_count), 64'd0);
         rst_n = 1'b1;
         tick();
         tick();
         chk(g, "idle_ready", 64'(in_ready), 64'd1);

         ones = (64'd1 << W) - 1;
         msb  = 64'd1 << (W-1);
         alt  = '0;
         for (int i = 0; i < W; i += 2) alt[i] = 1'b1;

         send(64'h000B, 1'b0, 64'h10, 64'h5, 3, 1'b1);
         send(ones, 1'b0, 64'd1 << W, 64'd1, 2, 1'b1);
         send(ones, 1'b1, 64'd0, 64'd1, 1, 1'b1);
         send(msb, 1'b1, 64'd0, msb, 1, 1'b1);
         send(msb, 1'b0, msb, 64'd0, 1, 1'b1);
         send(alt, 1'b0, alt, 64'd0, (W+1)/2, 1'b1);
         send(64'd0, 1'b0, 64'd0, 64'd0, 0, 1'b1);
         send(64'd0, 1'b1, 64'd0, 64'd0, 0, 1'b1);
         drain();

         out_ready = 1'b0;
         send_m(W'($urandom) | W'(1), 1'b0);
         sel = 0;
         while (!out_valid && sel < 100) begin
            tick();
            sel++;
         end
         chk(g, "bp_valid", 64'(out_valid), 64'd1);
         repeat (10) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            tick();
            chk(g, "bp_in_ready", 64'(in_ready), 64'd0);
            chk(g, "bp_out_valid", 64'(out_valid), 64'd1);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         tick();
         chk(g, "hs_out_valid", 64'(out_valid), 64'd0);
         chk(g, "hs_in_ready", 64'(in_ready), 64'd1);
         drain();

         send(64'(W'($urandom) | W'(1)), 1'b0, 64'd0, 64'd0, 0, 1'b0);
         repeat ((NS > 5) ? 4 : 1) tick();
         rst_n = 1'b0;
         #1;
         chk(g, "mid_rst_valid", 64'(out_valid), 64'd0);
         chk(g, "mid_rst_ready", 64'(in_ready), 64'd0);
         chk(g, "mid_rst_pos", 64'(out_pos), 64'd0);
         chk(g, "mid_rst_neg", 64'(out_neg), 64'd0);
         chk(g, "mid_rst_nz", 64'(nz_count), 64'd0);
         tick();
         rst_n = 1'b1;
         repeat (NS + 5) begin
            tick();
            chk(g, "no_valid_after_rst", 64'(out_valid), 64'd0);
         end
         send(64'h7, 1'b0, 64'h8, 64'h1, 2, 1'b1);
         drain();

         rmode = 1'b1;
         repeat (340) begin
            sel = int'($urandom % 8);
            unique case (sel)
               0:       d = '0;
               1:       d = '1;
               2:       d = W'(msb);
               3:       d = W'(msb) | W'(1);
               default: d = W'($urandom);
            endcase
            send_m(d, bit'($urandom % 2));
            repeat ($urandom % 3) tick();
         end
         drain();
         rmode     = 1'b0;
         out_ready = 1'b1;
         fin       = 1'b1;
      end
   end

   initial begin
      int n;
      n = 0;
      while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && n < 60000) begin
         @(posedge clk);
         n++;
      end
      chk(9, "all_done",
          64'({cfg[2].fin, cfg[1].fin, cfg[0].fin}), 64'd7);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
